// File: rtl/rom_load_pkg.sv
// Shared types and default region boundaries for the ROM download sequencer.
package rom_load_pkg;

  typedef enum logic [2:0] {
    BOOT,
    LOAD,
    HOLD,
    RUN,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    REG_PROG,
    REG_GFX,
    REG_PROM,
    REG_NONE
  } region_e;

  localparam logic [15:0] PROG_END_DEF  = 16'h4000;
  localparam logic [15:0] GFX_END_DEF   = 16'h6000;
  localparam logic [15:0] ROM_TOTAL_DEF = 16'h6200;
  localparam int          RST_HOLD_DEF  = 16;

endpackage

// File: rtl/rom_region_decode.sv
// Maps an ioctl byte address onto a ROM region and its region-relative offset.
module rom_region_decode
  import rom_load_pkg::*;
#(
  parameter logic [15:0] PROG_END  = PROG_END_DEF,
  parameter logic [15:0] GFX_END   = GFX_END_DEF,
  parameter logic [15:0] ROM_TOTAL = ROM_TOTAL_DEF
) (
  input  logic [24:0] addr,
  output region_e     region,
  output logic [15:0] offset
);

  logic [15:0] addr_lo;
  assign addr_lo = addr[15:0];

  always_comb begin
    region = REG_NONE;
    offset = 16'h0000;
    // Anything with upper address bits set lies past the image.
    if (addr[24:16] == 9'd0) begin
      if (addr_lo < PROG_END) begin
        region = REG_PROG;
        offset = addr_lo;
      end else if (addr_lo < GFX_END) begin
        region = REG_GFX;
        offset = addr_lo - PROG_END;
      end else if (addr_lo < ROM_TOTAL) begin
        region = REG_PROM;
        offset = addr_lo - GFX_END;
      end
    end
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// Steers ioctl download bytes into the ROM regions, validates the image and
// owns the core reset, releasing it a fixed time after a good load.
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter logic [15:0] PROG_END  = PROG_END_DEF,
  parameter logic [15:0] GFX_END   = GFX_END_DEF,
  parameter logic [15:0] ROM_TOTAL = ROM_TOTAL_DEF,
  parameter int          RST_HOLD  = RST_HOLD_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        user_reset,
  output logic        prog_we,
  output logic        gfx_we,
  output logic        prom_we,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        core_reset,
  output logic        dl_done,
  output logic        dl_error,
  output logic [7:0]  checksum
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int CNT_W  = 17;

  state_e              state_q, state_d;
  logic                dl_active_q;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]          checksum_q, checksum_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                prog_we_q, prog_we_d;
  logic                gfx_we_q, gfx_we_d;
  logic                prom_we_q, prom_we_d;
  logic [15:0]         wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                core_reset_q, core_reset_d;

  region_e             region;
  logic [15:0]         offset;
  logic                dl_rise, dl_fall;
  logic                accept, reject;
  logic [CNT_W-1:0]    cnt_inc;
  logic                ovf_now;

  rom_region_decode #(
    .PROG_END  (PROG_END),
    .GFX_END   (GFX_END),
    .ROM_TOTAL (ROM_TOTAL)
  ) u_decode (
    .addr   (dl_addr),
    .region (region),
    .offset (offset)
  );

  assign dl_rise = dl_active & ~dl_active_q;
  assign dl_fall = ~dl_active & dl_active_q;
  assign accept  = (state_q == LOAD) && dl_wr && (region != REG_NONE);
  assign reject  = (state_q == LOAD) && dl_wr && (region == REG_NONE);
  // Saturate so a runaway stream of duplicates cannot wrap back to a valid count.
  assign cnt_inc = !accept ? byte_cnt_q :
                   (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
  assign ovf_now = ovf_q | reject;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    byte_cnt_d = byte_cnt_q;
    checksum_d = checksum_q;
    ovf_d      = ovf_q;
    done_d     = done_q;
    error_d    = error_q;
    prog_we_d  = 1'b0;
    gfx_we_d   = 1'b0;
    prom_we_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (accept) begin
      prog_we_d  = (region == REG_PROG);
      gfx_we_d   = (region == REG_GFX);
      prom_we_d  = (region == REG_PROM);
      wr_addr_d  = offset;
      wr_data_d  = dl_data;
      checksum_d = checksum_q + dl_data;
      byte_cnt_d = cnt_inc;
    end
    if (reject) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      LOAD: begin
        // The byte arriving with the fall is already folded into cnt_inc/ovf_now.
        if (dl_fall) begin
          if ((cnt_inc == {1'b0, ROM_TOTAL}) && !ovf_now) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            done_d     = 1'b1;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (user_reset) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (user_reset) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
      end
    endcase

    if (dl_rise) begin
      state_d    = LOAD;
      byte_cnt_d = '0;
      checksum_d = 8'h00;
      ovf_d      = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
    end

    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      dl_active_q  <= 1'b0;
      hold_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      checksum_q   <= 8'h00;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      prog_we_q    <= 1'b0;
      gfx_we_q     <= 1'b0;
      prom_we_q    <= 1'b0;
      wr_addr_q    <= 16'h0000;
      wr_data_q    <= 8'h00;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      dl_active_q  <= dl_active;
      hold_cnt_q   <= hold_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      checksum_q   <= checksum_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      error_q      <= error_d;
      prog_we_q    <= prog_we_d;
      gfx_we_q     <= gfx_we_d;
      prom_we_q    <= prom_we_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign prog_we    = prog_we_q;
  assign gfx_we     = gfx_we_q;
  assign prom_we    = prom_we_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_reset = core_reset_q;
  assign dl_done    = done_q;
  assign dl_error   = error_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed scenarios for the ROM download sequencer: boot, loads, errors, resets.
module tb_rom_load_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        user_reset;
  logic        prog_we, gfx_we, prom_we;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_reset, dl_done, dl_error;
  logic [7:0]  checksum;

  int total = 0;
  int bad   = 0;

  int n_prog = 0, n_gfx = 0, n_prom = 0, n_multi = 0;

  logic        snap_gfx, snap_prog;
  logic [15:0] snap_addr;
  logic [7:0]  snap_data;
  logic        snap_ovf_we;
  logic        snap_last_prom, snap_last_core;
  logic [15:0] snap_last_addr;
  logic [7:0]  snap_last_data;

  rom_load_sequencer dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .user_reset (user_reset),
    .prog_we    (prog_we),
    .gfx_we     (gfx_we),
    .prom_we    (prom_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_reset (core_reset),
    .dl_done    (dl_done),
    .dl_error   (dl_error),
    .checksum   (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (prog_we) n_prog++;
    if (gfx_we)  n_gfx++;
    if (prom_we) n_prom++;
    if ((32'(prog_we) + 32'(gfx_we) + 32'(prom_we)) > 1) n_multi++;
  end

  // Drives a complete download of addresses 0..n-1 with data = addr[7:0].
  task automatic drive_load(input int n, input bit coincident, input bit inject_ovf);
    n_prog = 0; n_gfx = 0; n_prom = 0; n_multi = 0;
    snap_gfx = 1'b0; snap_prog = 1'b1; snap_addr = 16'hFFFF; snap_data = 8'h00;
    snap_ovf_we = 1'b1;
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys);
    for (int a = 0; a < n; a++) begin
      @(negedge clk_sys);
      if (a == 32'h4006) begin
        snap_gfx = gfx_we; snap_prog = prog_we; snap_addr = wr_addr; snap_data = wr_data;
      end
      if (inject_ovf && a == 32'h3000) begin
        dl_wr = 1'b1; dl_addr = 25'h0006200; dl_data = 8'hA5;
        @(negedge clk_sys);
        snap_ovf_we = prog_we | gfx_we | prom_we;
      end
      dl_wr   = 1'b1;
      dl_addr = 25'(a);
      dl_data = 8'(a);
      if (coincident && a == n - 1) dl_active = 1'b0;
    end
    @(negedge clk_sys);
    snap_last_prom = prom_we; snap_last_addr = wr_addr;
    snap_last_data = wr_data; snap_last_core = core_reset;
    dl_wr = 1'b0;
    if (!coincident) dl_active = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0; user_reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    total++;
    if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_error !== 1'b0 || checksum !== 8'h00 ||
        prog_we !== 1'b0 || gfx_we !== 1'b0 || prom_we !== 1'b0 || wr_addr !== 16'h0 || wr_data !== 8'h0) begin
      bad++;
      $display("FAIL reset_values: got rst=%b done=%b err=%b cs=%h we=%b%b%b addr=%h data=%h want rst=1 all others 0",
               core_reset, dl_done, dl_error, checksum, prog_we, gfx_we, prom_we, wr_addr, wr_data);
    end
    reset_n = 1'b1;
    n_prog = 0; n_gfx = 0; n_prom = 0;
    repeat (10) @(negedge clk_sys);
    user_reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    user_reset = 1'b0;
    repeat (30) @(negedge clk_sys);
    total++;
    if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_error !== 1'b0) begin
      bad++;
      $display("FAIL boot_idle: got rst=%b done=%b err=%b want rst=1 done=0 err=0", core_reset, dl_done, dl_error);
    end
    total++;
    if (n_prog + n_gfx + n_prom !== 0) begin
      bad++;
      $display("FAIL boot_no_strobe: got %0d strobes want 0", n_prog + n_gfx + n_prom);
    end
    $display("test_reset done");
  endtask

  task automatic test_short_load();
    drive_load(32'h61FF, 1'b0, 1'b0);
    @(negedge clk_sys);
    total++;
    if (dl_error !== 1'b1 || dl_done !== 1'b0 || core_reset !== 1'b1) begin
      bad++;
      $display("FAIL short_status: got err=%b done=%b rst=%b want err=1 done=0 rst=1", dl_error, dl_done, core_reset);
    end
    total++;
    if (checksum !== 8'h01) begin
      bad++;
      $display("FAIL short_checksum: got %h want 01", checksum);
    end
    repeat (40) @(negedge clk_sys);
    total++;
    if (core_reset !== 1'b1 || dl_error !== 1'b1) begin
      bad++;
      $display("FAIL short_stays_error: got rst=%b err=%b want rst=1 err=1", core_reset, dl_error);
    end
    total++;
    if (n_prog !== 32'h4000 || n_gfx !== 32'h2000 || n_prom !== 32'h1FF) begin
      bad++;
      $display("FAIL short_counts: got %0h/%0h/%0h want 4000/2000/1ff", n_prog, n_gfx, n_prom);
    end
    $display("test_short_load done");
  endtask

  task automatic test_valid_load();
    drive_load(32'h6200, 1'b1, 1'b0);
    total++;
    if (snap_gfx !== 1'b1 || snap_prog !== 1'b0 || snap_addr !== 16'h0005 || snap_data !== 8'h05) begin
      bad++;
      $display("FAIL byte_4005: got gfx=%b prog=%b addr=%h data=%h want gfx=1 prog=0 addr=0005 data=05",
               snap_gfx, snap_prog, snap_addr, snap_data);
    end
    total++;
    if (snap_last_prom !== 1'b1 || snap_last_addr !== 16'h01FF || snap_last_data !== 8'hFF) begin
      bad++;
      $display("FAIL last_byte_coincident: got prom=%b addr=%h data=%h want prom=1 addr=01ff data=ff",
               snap_last_prom, snap_last_addr, snap_last_data);
    end
    total++;
    if (dl_done !== 1'b1 || dl_error !== 1'b0 || checksum !== 8'h00 || core_reset !== 1'b1) begin
      bad++;
      $display("FAIL valid_status: got done=%b err=%b cs=%h rst=%b want done=1 err=0 cs=00 rst=1",
               dl_done, dl_error, checksum, core_reset);
    end
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_sys);
      total++;
      if (core_reset !== 1'b1) begin
        bad++;
        $display("FAIL hold_cycle_%0d: got core_reset=%b want 1", i, core_reset);
      end
    end
    @(negedge clk_sys);
    total++;
    if (core_reset !== 1'b0) begin
      bad++;
      $display("FAIL release_at_16: got core_reset=%b want 0", core_reset);
    end
    total++;
    if (n_prog !== 32'h4000 || n_gfx !== 32'h2000 || n_prom !== 32'h200 || n_multi !== 0) begin
      bad++;
      $display("FAIL valid_counts: got %0h/%0h/%0h multi=%0d want 4000/2000/200 multi=0",
               n_prog, n_gfx, n_prom, n_multi);
    end
    $display("test_valid_load done");
  endtask

  task automatic test_user_reset();
    @(negedge clk_sys);
    user_reset = 1'b1;
    @(negedge clk_sys);
    total++;
    if (core_reset !== 1'b1) begin
      bad++;
      $display("FAIL user_reset_assert: got core_reset=%b want 1", core_reset);
    end
    repeat (2) @(negedge clk_sys);
    user_reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_sys);
      total++;
      if (core_reset !== 1'b1) begin
        bad++;
        $display("FAIL user_hold_cycle_%0d: got core_reset=%b want 1", i, core_reset);
      end
    end
    @(negedge clk_sys);
    total++;
    if (core_reset !== 1'b0 || dl_done !== 1'b1) begin
      bad++;
      $display("FAIL user_release: got core_reset=%b done=%b want 0 1", core_reset, dl_done);
    end
    $display("test_user_reset done");
  endtask

  task automatic test_overflow();
    drive_load(32'h6200, 1'b0, 1'b1);
    @(negedge clk_sys);
    total++;
    if (snap_ovf_we !== 1'b0) begin
      bad++;
      $display("FAIL ovf_no_strobe: got we=%b want 0", snap_ovf_we);
    end
    total++;
    if (dl_error !== 1'b1 || dl_done !== 1'b0 || core_reset !== 1'b1 || checksum !== 8'h00) begin
      bad++;
      $display("FAIL ovf_status: got err=%b done=%b rst=%b cs=%h want err=1 done=0 rst=1 cs=00",
               dl_error, dl_done, core_reset, checksum);
    end
    total++;
    if (n_prog !== 32'h4000 || n_gfx !== 32'h2000 || n_prom !== 32'h200) begin
      bad++;
      $display("FAIL ovf_counts: got %0h/%0h/%0h want 4000/2000/200", n_prog, n_gfx, n_prom);
    end
    user_reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    user_reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    total++;
    if (core_reset !== 1'b1 || dl_error !== 1'b1) begin
      bad++;
      $display("FAIL error_ignores_user_reset: got rst=%b err=%b want 1 1", core_reset, dl_error);
    end
    $display("test_overflow done");
  endtask

  task automatic test_reset_midload();
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys);
    for (int a = 0; a < 256; a++) begin
      @(negedge clk_sys);
      dl_wr = 1'b1; dl_addr = 25'(a + 32'h4100); dl_data = 8'(a + 3);
    end
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    total++;
    if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_error !== 1'b0 || checksum !== 8'h00 ||
        prog_we !== 1'b0 || gfx_we !== 1'b0 || prom_we !== 1'b0 || wr_addr !== 16'h0 || wr_data !== 8'h0) begin
      bad++;
      $display("FAIL midload_reset: got rst=%b done=%b err=%b cs=%h we=%b%b%b addr=%h data=%h want rst=1 all others 0",
               core_reset, dl_done, dl_error, checksum, prog_we, gfx_we, prom_we, wr_addr, wr_data);
    end
    dl_wr = 1'b0; dl_active = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    n_prog = 0; n_gfx = 0; n_prom = 0;
    @(negedge clk_sys);
    dl_wr = 1'b1; dl_addr = 25'h10; dl_data = 8'h77;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    repeat (30) @(negedge clk_sys);
    total++;
    if (core_reset !== 1'b1 || dl_done !== 1'b0 || n_prog + n_gfx + n_prom !== 0 || wr_data !== 8'h00) begin
      bad++;
      $display("FAIL boot_after_reset: got rst=%b done=%b strobes=%0d data=%h want rst=1 done=0 strobes=0 data=00",
               core_reset, dl_done, n_prog + n_gfx + n_prom, wr_data);
    end
    $display("test_reset_midload done");
  endtask

  initial begin
    test_reset();
    test_short_load();
    test_valid_load();
    test_user_reset();
    test_overflow();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
Sequences HPS ioctl ROM downloads into the core's three ROM regions: program, graphics and colour/sound PROM. It decodes each download byte into a per-region write strobe, counts and checksums the accepted bytes, and validates the download length. It owns the core reset: reset is held from power-up until a valid download finishes, then stretched for a fixed number of cycles before release. The block sits between hps_io and the arcade core, replacing direct ioctl wiring and the ad-hoc ioctl_download term in the reset expression.

Parameters:
- PROG_END, 16'h4000, first address past the program region (program = 0 .. PROG_END-1).
- GFX_END, 16'h6000, first address past the graphics region (graphics = PROG_END .. GFX_END-1).
- ROM_TOTAL, 16'h6200, exact byte count of a valid image (PROM = GFX_END .. ROM_TOTAL-1).
- RST_HOLD, 16, cycles core_reset stays high after a valid load or a user reset.

Ports:
- clk_sys, input, 1, system clock; all logic on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- dl_active, input, 1, ioctl_download level.
- dl_wr, input, 1, ioctl_wr byte strobe, one cycle per byte.
- dl_addr, input, 25, ioctl_addr.
- dl_data, input, 8, ioctl_dout.
- user_reset, input, 1, OSD or button reset request (level).
- prog_we, output, 1, program ROM write strobe.
- gfx_we, output, 1, graphics ROM write strobe.
- prom_we, output, 1, PROM write strobe.
- wr_addr, output, 16, region-relative byte address.
- wr_data, output, 8, registered data byte.
- core_reset, output, 1, active-high reset to the core.
- dl_done, output, 1, high while the last download was valid.
- dl_error, output, 1, high while the last download was invalid.
- checksum, output, 8, modulo-256 sum of accepted bytes from the last download.

Behaviour:
- Reset values: all *_we=0, wr_addr=0, wr_data=0, core_reset=1, dl_done=0, dl_error=0, checksum=0, byte counter=0, hold counter=0, state=BOOT.
- States:
  - BOOT: no image loaded; core_reset=1. Leaves on a dl_active rise.
  - LOAD: accepts bytes; core_reset=1.
  - HOLD: core_reset=1; counts RST_HOLD cycles.
  - RUN: core_reset=0.
  - ERROR: core_reset=1; dl_error=1.
- A rising edge of dl_active in any state goes to LOAD. On that edge, clear the byte count, checksum, dl_done and dl_error.
- In LOAD, a byte is accepted when dl_wr=1 and dl_addr < ROM_TOTAL with dl_addr[24:16]=0:
  - Exactly one *_we pulses for one cycle, 1 cycle after dl_wr.
  - wr_addr is dl_addr minus the region base; wr_data is registered dl_data.
  - The byte count increments and checksum += dl_data, wrapping at 8 bits.
- Any dl_wr with an address at or above ROM_TOTAL is not written and sets a sticky overflow flag for the current load.
- dl_wr while not in LOAD is ignored entirely.
- dl_active falling in LOAD:
  - Valid (count == ROM_TOTAL and no overflow): go to HOLD, dl_done=1.
  - Otherwise: go to ERROR.
- A dl_wr in the same cycle as the dl_active fall is accepted and counted before the check.
- Duplicate addresses are counted twice and are not detected.
- HOLD: the counter runs 0..RST_HOLD-1, then the block enters RUN. core_reset drops on the first RUN cycle, i.e. exactly RST_HOLD cycles after entering HOLD.
- user_reset=1 in RUN or HOLD: go to (or restart) HOLD with the counter cleared. Held high, it keeps the core in reset; RUN follows RST_HOLD cycles after release.
- user_reset is ignored in BOOT, LOAD and ERROR.
- ERROR persists until the next dl_active rise.
- An asynchronous reset mid-load returns to BOOT. Any partial image is discarded logically and a new download is required.

Decomposition:
- Shared package rom_load_pkg holds:
  - State enum: BOOT, LOAD, HOLD, RUN, ERROR.
  - Region enum: REG_PROG, REG_GFX, REG_PROM, REG_NONE.
  - Default boundary constants.
- One sub-module, rom_region_decode: purely combinational. It maps the address to the region code and the region-relative offset, and is instantiated once.

Test Plan:
- Reset, no download: core_reset=1 and dl_done=0 indefinitely; no *_we pulses.
- Full valid load of 0x6200 bytes with data = addr[7:0]:
  - Exactly 0x4000 prog_we, 0x2000 gfx_we and 0x200 prom_we pulses.
  - Byte 0x4005 gives gfx_we with wr_addr=0x0005.
  - Final checksum=0x00; dl_done=1.
  - core_reset falls exactly 16 cycles after dl_active falls.
- Short load of 0x61FF bytes: dl_error=1, core_reset stays 1. A following valid load reaches RUN with dl_error=0.
- Write to 0x6200 during an otherwise full load: no strobe, ERROR at end.
- dl_wr coincident with the dl_active fall on the final byte (0x61FF): the byte is written via prom_we with wr_addr=0x01FF; the load is valid.
- user_reset pulsed for 3 cycles in RUN: core_reset=1 immediately, then low 16 cycles after user_reset deasserts. Also assert reset_n mid-LOAD: state=BOOT, all outputs at reset values.
